// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states, requester IDs, word shift.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DBG   = 1'b1;
  localparam int   WORD_SHIFT = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes plus RAM pins of the data-RAM arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req0, we0, ack0, err0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0, rdata0;
  logic                  req1, we1, ack1, err1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1, rdata1;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_write, ram_data_out;
  logic                  ram_write_en, ram_read_en;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_data_out,
    output ack0, err0, rdata0, ack1, err1, rdata1,
           ram_address, ram_data_write, ram_write_en, ram_read_en
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_data_out,
    input  ack0, err0, rdata0, ack1, err1, rdata1,
           ram_address, ram_data_write, ram_write_en, ram_read_en
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the port that did not win last time goes.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~last_grant : req[1];
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between CPU (port 0) and debug loader (port 1).
// Optional DMEM_ARB_BOUNDS_CHECK_EN flags word indices >= DEPTH and suppresses the RAM access.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("dmem_arbiter: DEPTH must be at least 1");
  end

  logic [1:0]                 req, we_in;
  logic [1:0][ADDR_WIDTH-1:0] addr_in;
  logic [1:0][DATA_WIDTH-1:0] wdata_in;

  assign req      = {bus.req1,   bus.req0};
  assign we_in    = {bus.we1,    bus.we0};
  assign addr_in  = {bus.addr1,  bus.addr0};
  assign wdata_in = {bus.wdata1, bus.wdata0};

  state_t                     state, state_nxt;
  logic                       sel, lat_we, lat_bad, last_grant;
  logic                       gnt_valid, gnt_id, grant_bad;
  logic                       access, rd_en;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  assign grant_bad = (addr_in[gnt_id] >> WORD_SHIFT) >= ADDR_WIDTH'(DEPTH);
`else
  assign grant_bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gating with reset drops an in-flight strobe in the same cycle, so the RAM never commits it.
  assign access = (state == ACCESS) && !lat_bad && !reset;
  assign rd_en  = access && !lat_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= PORT_CPU;
      lat_we     <= 1'b0;
      lat_bad    <= 1'b0;
      last_grant <= PORT_DBG;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gnt_valid) begin
        sel     <= gnt_id;
        lat_we  <= we_in[gnt_id];
        lat_bad <= grant_bad;
        addr_q  <= addr_in[gnt_id];
        // Reads leave the write-data pins at their previous value.
        if (we_in[gnt_id]) wdata_q <= wdata_in[gnt_id];
      end
      if (state == ACCESS) begin
        last_grant <= sel;
        if (rd_en) rdata_q[sel] <= bus.ram_data_out;
      end
    end
  end

  assign bus.ram_address    = addr_q;
  assign bus.ram_data_write = wdata_q;
  assign bus.ram_write_en   = access && lat_we;
  assign bus.ram_read_en    = rd_en;

  assign bus.ack0   = (state == RESP) && (sel == PORT_CPU);
  assign bus.ack1   = (state == RESP) && (sel == PORT_DBG);
  assign bus.err0   = bus.ack0 && lat_bad;
  assign bus.err1   = bus.ack1 && lat_bad;
  assign bus.rdata0 = rdata_q[PORT_CPU];
  assign bus.rdata1 = rdata_q[PORT_DBG];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a word-array RAM and a transaction-level model.
module tb_dmem_arbiter;
  localparam int DW = 32, AW = 32, DEPTH = 32;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0, n_fail = 0, cyc = 0, we_seen = 0;
  int ack_cnt [2];
  int ack_log [$];
  int ack_cyc [$];
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_rd [2];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // RAM: combinational read, write on the edge, cleared by reset; out-of-range words do not exist.
  wire [AW-1:0] ram_idx = bus.ram_address >> 2;
  assign bus.ram_data_out = (ram_idx < DEPTH) ? ram[ram_idx[4:0]] : '0;
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    else if (bus.ram_write_en && ram_idx < DEPTH) ram[ram_idx[4:0]] <= bus.ram_data_write;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one transaction at a time per port, evaluated at issue.
  function automatic exp_t model(int p, bit we, logic [31:0] a, logic [31:0] d);
    exp_t e;
    int unsigned idx = a >> 2;
    bit oob = (idx >= DEPTH);
    e.err = 1'b0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    if (oob) begin
      e.err = 1'b1;
      e.rdata = last_rd[p];
      return e;
    end
`endif
    if (we) begin
      if (!oob) ref_mem[idx] = d;
    end else begin
      last_rd[p] = oob ? '0 : ref_mem[idx];
    end
    e.rdata = last_rd[p];
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endfunction

  // Monitor: pops the port's expectation on every ack, plus protocol checks.
  logic [1:0] prev_ack = 2'b00;
  always @(negedge clk) begin
    logic [1:0] a;
    exp_t e;
    bit have;
    a = {bus.ack1, bus.ack0};
    if (bus.ram_write_en) we_seen++;
    if (bus.ram_write_en && bus.ram_read_en) fail("rd_wr_overlap");
    if (reset) begin
      chk("reset_wr_en", bus.ram_write_en, 0);
      chk("reset_rd_en", bus.ram_read_en, 0);
      prev_ack = 2'b00;
    end else begin
      if (&a) fail("dual_ack");
      for (int p = 0; p < 2; p++) begin
        if (a[p]) begin
          ack_cnt[p]++;
          ack_log.push_back(p);
          ack_cyc.push_back(cyc);
          if (prev_ack[p]) fail($sformatf("ack%0d_width", p));
          have = (p == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          if (!have) fail($sformatf("ack%0d_spurious", p));
          else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rdata%0d", p), (p == 0) ? bus.rdata0 : bus.rdata1, e.rdata);
            chk($sformatf("err%0d", p), (p == 0) ? bus.err0 : bus.err1, e.err);
          end
        end
      end
      prev_ack = a;
    end
  end

  // One request on port p; scramble changes the inputs after grant to prove they are latched.
  task automatic xact(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit scramble, output int lat);
    exp_t e;
    @(posedge clk); #1;
    e = model(p, we, a, d);
    if (p == 0) begin
      exp_q0.push_back(e);
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      exp_q1.push_back(e);
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.ack0 : bus.ack1) begin
        lat = i;
        break;
      end
      if (scramble && i == 1) begin
        if (p == 0) begin bus.addr0 = a ^ 32'h4; bus.we0 = ~we; bus.wdata0 = ~d; end
        else        begin bus.addr1 = a ^ 32'h4; bus.we1 = ~we; bus.wdata1 = ~d; end
      end
    end
    if (lat < 0) fail($sformatf("ack%0d_timeout", p));
    @(posedge clk); #1;
    if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(int p);
    return ((p == 0) ? $urandom_range(0, 15) : $urandom_range(16, 31)) * 4 + $urandom_range(0, 3);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, l0, l1, n, base, c1, w0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", bus.ack0, 0);   chk("rst_ack1", bus.ack1, 0);
    chk("rst_err0", bus.err0, 0);   chk("rst_err1", bus.err1, 0);
    chk("rst_rdata0", bus.rdata0, 0); chk("rst_rdata1", bus.rdata1, 0);
    chk("rst_ram_addr", bus.ram_address, 0);
    chk("rst_ram_wdata", bus.ram_data_write, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Write then read back on port 0, two-cycle latency from idle.
    xact(0, 1'b1, 32'h28, 32'hE, 1'b0, lat);  chk("t1_wr_latency", lat, 2);
    xact(0, 1'b0, 32'h28, 32'h0, 1'b0, lat);  chk("t1_rd_latency", lat, 2);
    chk("t1_rdata0_hold", bus.rdata0, 32'hE);

    // Preload every word; port 1 goes last so a tie next favours port 0.
    for (int w = 0; w < DEPTH; w++) xact((w < 16) ? 0 : 1, 1'b1, w * 4, $urandom, 1'b0, lat);

    // Simultaneous reads: port 0 first, port 1 three cycles later.
    fork
      xact(0, 1'b0, 32'h28, 32'h0, 1'b0, l0);
      xact(1, 1'b0, 32'h48, 32'h0, 1'b0, l1);
    join
    n = ack_log.size();
    chk("t2_first_port", ack_log[n-2], 0);
    chk("t2_second_port", ack_log[n-1], 1);
    chk("t2_ack_gap", ack_cyc[n-1] - ack_cyc[n-2], 3);

    // Six back-to-back reads on each port: strict alternation.
    base = ack_log.size();
    fork
      for (int i = 0; i < 6; i++) xact(0, 1'b0, rand_addr(0), 32'h0, 1'b0, l0);
      for (int i = 0; i < 6; i++) xact(1, 1'b0, rand_addr(1), 32'h0, 1'b0, l1);
    join
    chk("t3_ack_total", ack_log.size() - base, 12);
    for (int k = 0; k < 12 && base + k < ack_log.size(); k++)
      chk($sformatf("t3_order_%0d", k), ack_log[base+k], k % 2);

    // Port 0 alone with inputs changed after grant.
    c1 = ack_cnt[1];
    xact(0, 1'b0, 32'h10, 32'h0, 1'b1, lat);
    chk("t6_latency", lat, 2);
    chk("t6_no_ack1", ack_cnt[1], c1);

    // Random mix of single and concurrent traffic, including writes and unaligned addresses.
    for (int it = 0; it < 30; it++) begin
      int mode = $urandom_range(0, 2);
      if (mode == 2) begin
        fork
          xact(0, 1'($urandom), rand_addr(0), $urandom, 1'b0, l0);
          xact(1, 1'($urandom), rand_addr(1), $urandom, 1'b0, l1);
        join
      end else begin
        xact(mode, 1'($urandom), rand_addr(mode), $urandom, 1'b0, lat);
      end
    end

    // Out-of-range address on port 1.
    w0 = we_seen;
    xact(1, 1'b1, 32'h80, 32'hDEAD, 1'b0, lat);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    chk("t5_oob_strobes", we_seen - w0, 0);
`else
    chk("t5_oob_strobes", we_seen - w0, 1);
`endif
    xact(1, 1'b0, 32'h80, 32'h0, 1'b0, lat);

    // Reset while a port-1 write is in ACCESS.
    @(posedge clk); #1;
    c1 = ack_cnt[1];
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h2C; bus.wdata1 = 32'h1234;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("t4_wr_en_killed", bus.ram_write_en, 0);
    @(posedge clk); #1 bus.req1 = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("t4_no_ack1", ack_cnt[1], c1);
    xact(1, 1'b0, 32'h2C, 32'h0, 1'b0, lat);
    chk("t4_rd_latency", lat, 2);

    // First tie after reset goes to port 0.
    fork
      xact(0, 1'b0, 32'h0, 32'h0, 1'b0, l0);
      xact(1, 1'b0, 32'h40, 32'h0, 1'b0, l1);
    join
    n = ack_log.size();
    chk("t4_tie_after_reset", ack_log[n-2], 0);

    repeat (3) @(negedge clk);
    chk("exp_q0_drained", exp_q0.size(), 0);
    chk("exp_q1_drained", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
